// File: rtl/mfb2dma_split_if.sv
// Header, frame and DMA bus signals of mfb2dma_split bundled for port connection.
// The slave modport is the converter's view; master is the surrounding logic.
interface mfb2dma_split_if #(
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH  = 96
);
  logic [HDR_WIDTH-1:0]  RX_MVB_HDR;
  logic                  RX_MVB_VLD;
  logic                  RX_MVB_SRC_RDY;
  logic                  RX_MVB_DST_RDY;
  logic [DATA_WIDTH-1:0] RX_MFB_DATA;
  logic                  RX_MFB_SOF;
  logic                  RX_MFB_EOF;
  logic                  RX_MFB_SRC_RDY;
  logic                  RX_MFB_DST_RDY;
  logic [HDR_WIDTH-1:0]  TX_DMA_HDR;
  logic [DATA_WIDTH-1:0] TX_DMA_DATA;
  logic                  TX_DMA_SOP;
  logic                  TX_DMA_EOP;
  logic                  TX_DMA_SRC_RDY;
  logic                  TX_DMA_DST_RDY;
  logic                  ERR;

  modport slave (
    input  RX_MVB_HDR, RX_MVB_VLD, RX_MVB_SRC_RDY,
    output RX_MVB_DST_RDY,
    input  RX_MFB_DATA, RX_MFB_SOF, RX_MFB_EOF, RX_MFB_SRC_RDY,
    output RX_MFB_DST_RDY,
    output TX_DMA_HDR, TX_DMA_DATA, TX_DMA_SOP, TX_DMA_EOP, TX_DMA_SRC_RDY,
    input  TX_DMA_DST_RDY,
    output ERR
  );

  modport master (
    output RX_MVB_HDR, RX_MVB_VLD, RX_MVB_SRC_RDY,
    input  RX_MVB_DST_RDY,
    output RX_MFB_DATA, RX_MFB_SOF, RX_MFB_EOF, RX_MFB_SRC_RDY,
    input  RX_MFB_DST_RDY,
    input  TX_DMA_HDR, TX_DMA_DATA, TX_DMA_SOP, TX_DMA_EOP, TX_DMA_SRC_RDY,
    output TX_DMA_DST_RDY,
    input  ERR
  );
endinterface

// File: rtl/mfb2dma_split.sv
// Pairs MVB request headers with MFB frames and emits DMA transactions,
// splitting frames longer than MAX_PAYLOAD_DW into fragments with rewritten headers.
module mfb2dma_split #(
  parameter int DATA_WIDTH     = 512,
  parameter int HDR_WIDTH      = 96,
  parameter int MAX_PAYLOAD_DW = 128,
  parameter int HDR_FIFO_DEPTH = 8
) (
  input logic            CLK,
  input logic            RESET,
  mfb2dma_split_if.slave bus
);
  localparam int          BD        = DATA_WIDTH / 32;
  localparam int          AW        = $clog2(HDR_FIFO_DEPTH);
  localparam logic [12:0] BD_L      = 13'(BD);
  localparam logic [12:0] MAX_L     = 13'(MAX_PAYLOAD_DW);
  localparam logic [63:0] ADDR_STEP = 64'(4 * MAX_PAYLOAD_DW);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [HDR_WIDTH-1:0]  fifo_mem_r [HDR_FIFO_DEPTH];
  logic [AW:0]           wr_ptr_r, rd_ptr_r;
  logic                  full_s, empty_s, push_s, pop_s;
  logic [HDR_WIDTH-1:0]  head_s;

  logic [12:0]           rem_r, rem_nxt_s, fcnt_r, fcnt_nxt_s;
  logic [63:0]           addr_r, addr_nxt_s;
  logic [HDR_WIDTH-1:0]  hdr_r, hdr_nxt_s;
  logic                  err_r, err_set_s;

  logic                  accept_en_s, mfb_rdy_s, beat_s, process_s, sop_s, eop_s;
  logic [HDR_WIDTH-1:0]  cur_hdr_s, out_hdr_s;
  logic [12:0]           cur_rem_s, cur_fcnt_s, take_s, rem_after_s, fcnt_after_s, frag_len_s;
  logic [63:0]           cur_addr_s;

  logic                  out_vld_r, out_sop_r, out_eop_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [HDR_WIDTH-1:0]  out_hdr_r;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign push_s  = bus.RX_MVB_VLD && bus.RX_MVB_SRC_RDY && bus.RX_MVB_DST_RDY;

  // A full FIFO still takes a header in the cycle its head is popped.
  assign bus.RX_MVB_DST_RDY = !RESET && (!full_s || pop_s);

  assign accept_en_s        = !out_vld_r || bus.TX_DMA_DST_RDY;
  assign mfb_rdy_s          = !RESET && accept_en_s && ((state_r != IDLE) || !empty_s);
  assign bus.RX_MFB_DST_RDY = mfb_rdy_s;
  assign beat_s             = bus.RX_MFB_SRC_RDY && mfb_rdy_s;

  // In IDLE the SOF beat is processed straight from the FIFO head so frames run back to back.
  assign cur_hdr_s    = (state_r == IDLE) ? head_s : hdr_r;
  assign cur_addr_s   = (state_r == IDLE) ? head_s[75:12] : addr_r;
  assign cur_fcnt_s   = (state_r == IDLE) ? 13'd0 : fcnt_r;
  assign cur_rem_s    = (state_r != IDLE) ? rem_r :
                        (head_s[11:0] == 12'd0) ? 13'd4096 : {1'b0, head_s[11:0]};
  assign take_s       = (cur_rem_s < BD_L) ? cur_rem_s : BD_L;
  assign frag_len_s   = (cur_rem_s < MAX_L) ? cur_rem_s : MAX_L;
  assign rem_after_s  = cur_rem_s - take_s;
  assign fcnt_after_s = cur_fcnt_s + BD_L;

  // Fragment header rewrite
  always_comb begin
    out_hdr_s         = cur_hdr_s;
    out_hdr_s[11:0]   = frag_len_s[11:0];
    out_hdr_s[75:12]  = cur_addr_s;
    out_hdr_s[84]     = (cur_rem_s <= MAX_L);
  end

  // Next-state and per-beat fragment bookkeeping
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    fcnt_nxt_s  = fcnt_r;
    addr_nxt_s  = addr_r;
    hdr_nxt_s   = hdr_r;
    err_set_s   = 1'b0;
    pop_s       = 1'b0;
    process_s   = 1'b0;
    sop_s       = 1'b0;
    eop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (beat_s && bus.RX_MFB_SOF) begin
          pop_s     = 1'b1;
          process_s = 1'b1;
        end else begin
          err_set_s = beat_s;
        end
      end
      XFER: begin
        process_s = beat_s;
        err_set_s = beat_s && bus.RX_MFB_SOF;
      end
      DRAIN: begin
        if (beat_s && bus.RX_MFB_EOF) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase

    if (process_s) begin
      sop_s       = (cur_fcnt_s == 13'd0);
      hdr_nxt_s   = cur_hdr_s;
      addr_nxt_s  = cur_addr_s;
      rem_nxt_s   = rem_after_s;
      fcnt_nxt_s  = fcnt_after_s;
      state_nxt_s = XFER;
      if (rem_after_s == 13'd0) begin
        eop_s      = 1'b1;
        fcnt_nxt_s = 13'd0;
        if (bus.RX_MFB_EOF) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
          err_set_s   = 1'b1;
        end
      end else if (bus.RX_MFB_EOF) begin
        eop_s       = 1'b1;
        fcnt_nxt_s  = 13'd0;
        err_set_s   = 1'b1;
        state_nxt_s = IDLE;
      end else if (fcnt_after_s >= MAX_L) begin
        eop_s      = 1'b1;
        fcnt_nxt_s = 13'd0;
        addr_nxt_s = cur_addr_s + ADDR_STEP;
      end else begin
        eop_s = 1'b0;
      end
    end else begin
      sop_s = 1'b0;
      eop_s = 1'b0;
    end
  end

  // FSM state, fragment counters and sticky error
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      rem_r   <= 13'd0;
      fcnt_r  <= 13'd0;
      addr_r  <= 64'd0;
      hdr_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
      addr_r  <= addr_nxt_s;
      hdr_r   <= hdr_nxt_s;
      err_r   <= err_r || err_set_s;
    end
  end

  // Header FIFO pointers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Header FIFO storage
  always_ff @(posedge CLK) begin
    if (push_s) fifo_mem_r[wr_ptr_r[AW-1:0]] <= bus.RX_MVB_HDR;
  end

  // Single output stage; holds its beat while the DMA bus stalls
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_vld_r  <= 1'b0;
      out_sop_r  <= 1'b0;
      out_eop_r  <= 1'b0;
      out_data_r <= '0;
      out_hdr_r  <= '0;
    end else if (accept_en_s) begin
      out_vld_r  <= process_s;
      out_sop_r  <= sop_s;
      out_eop_r  <= eop_s;
      out_data_r <= bus.RX_MFB_DATA;
      if (sop_s) out_hdr_r <= out_hdr_s;
    end
  end

  assign bus.TX_DMA_SRC_RDY = out_vld_r;
  assign bus.TX_DMA_SOP     = out_sop_r;
  assign bus.TX_DMA_EOP     = out_eop_r;
  assign bus.TX_DMA_DATA    = out_data_r;
  assign bus.TX_DMA_HDR     = out_hdr_r;
  assign bus.ERR            = err_r;
endmodule

// File: doc/mfb2dma_split.md
Name: mfb2dma_split

Overview:
- Successor of the single-transaction MFB-to-DMA converter.
- Pairs each MVB request header with its MFB frame and emits DMA bus transactions.
- Frames longer than MAX_PAYLOAD_DW are split into multiple DMA transactions. Each fragment carries a rewritten length and address.
- Sits between the PCIe down-path header/data streams and the DMA bus towards the DMA controllers.

Parameters:
- DATA_WIDTH, 512: MFB and DMA data width in bits; multiple of 32; beat dwords BD = DATA_WIDTH/32.
- HDR_WIDTH, 96: header width; must be >= 85.
- MAX_PAYLOAD_DW, 128: max dwords per DMA transaction; multiple of BD; must be >= BD.
- HDR_FIFO_DEPTH, 8: input header FIFO depth; power of two, >= 2.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- RX_MVB_HDR  in  HDR_WIDTH  request header: [11:0] LEN_DW, [75:12] ADDR (bytes), [83:76] TAG, [HDR_WIDTH-1:85] passthrough
- RX_MVB_VLD  in  1  header item valid
- RX_MVB_SRC_RDY  in  1  header source ready
- RX_MVB_DST_RDY  out  1  header FIFO not full
- RX_MFB_DATA  in  DATA_WIDTH  frame data, dword 0 in LSBs
- RX_MFB_SOF  in  1  start of frame (beat aligned)
- RX_MFB_EOF  in  1  end of frame
- RX_MFB_SRC_RDY  in  1  data valid
- RX_MFB_DST_RDY  out  1  data accepted
- TX_DMA_HDR  out  HDR_WIDTH  fragment header; valid on SOP beat
- TX_DMA_DATA  out  DATA_WIDTH  data
- TX_DMA_SOP  out  1  start of transaction
- TX_DMA_EOP  out  1  end of transaction
- TX_DMA_SRC_RDY  out  1  output valid
- TX_DMA_DST_RDY  in  1  output ready
- ERR  out  1  sticky protocol error

Behaviour:
- One clock domain (CLK). Reset is synchronous, active-high.
- Reset values:
  - TX_DMA_SRC_RDY=0, SOP=0, EOP=0, ERR=0.
  - Header FIFO empty; FSM in IDLE.
  - RX_MVB_DST_RDY=0 and RX_MFB_DST_RDY=0 while RESET=1.
  - Reset mid-frame discards all partial state; no output beat is issued after reset.
- Header FIFO:
  - Writes when RX_MVB_VLD & RX_MVB_SRC_RDY & RX_MVB_DST_RDY.
  - Items with VLD=0 are ignored.
  - DST_RDY=0 when full; a write and a read in the same cycle are allowed when full.
- Output register: a single stage, latency 1. An input beat is accepted when the stage is empty or TX_DMA_DST_RDY=1. The registered beat appears on TX the next cycle and is held stable while TX_DMA_DST_RDY=0.
- FSM:
  - IDLE:
    - RX_MFB_DST_RDY=0 unless the FIFO is non-empty.
    - On an accepted SOF beat: pop header; REM=LEN_DW; ADDR_CUR=ADDR; FCNT=0; go to XFER.
    - An SOF=0 beat arriving in IDLE sets ERR and is dropped.
  - XFER: each accepted beat does the following.
    - On the first beat of a fragment, SOP=1 and TX_DMA_HDR = input header with LEN_DW = min(REM, MAX_PAYLOAD_DW), ADDR=ADDR_CUR, bit84 LAST_FRAG = (REM <= MAX_PAYLOAD_DW), TAG and passthrough unchanged.
    - Each beat does REM -= min(REM, BD) and FCNT += BD.
    - EOP=1 when FCNT reaches MAX_PAYLOAD_DW or REM reaches 0. At a fragment EOP with REM>0: ADDR_CUR += 4*MAX_PAYLOAD_DW (64-bit wrap), FCNT=0.
    - When REM reaches 0, return to IDLE; SOF and EOF may be on the same beat.
- LEN_DW=0 encodes 4096 dwords. REM is 13 bits wide.
- Error checks (all set ERR, which stays set until RESET):
  - EOF on a beat where REM does not reach 0. The frame is terminated: the current beat gets EOP, then IDLE.
  - REM reaches 0 without EOF. Following beats are dropped until EOF.
  - SOF inside XFER.
- Throughput: one beat per cycle sustained, including across fragment boundaries and back-to-back frames.

Test Plan:
- BD=16, MAX=128. Header LEN_DW=16, ADDR=0x1000; single SOF+EOF beat -> one beat with SOP=EOP=1, LEN_DW=16, ADDR=0x1000, LAST_FRAG=1; latency 1 cycle.
- LEN_DW=300, ADDR=0x2000 (19 beats) -> 3 transactions: LEN 128/128/44; ADDR 0x2000/0x2200/0x2400; beats 8/8/3; LAST_FRAG only on the third; no idle cycles.
- Random TX_DMA_DST_RDY (50%) during the LEN_DW=300 case -> identical output sequence; data held stable while stalled; no beat lost or duplicated.
- 9 headers written with no MFB traffic -> RX_MVB_DST_RDY drops after 8 headers; after the first frame completes, the 9th header is accepted.
- LEN_DW=32 with EOF on beat 1 -> ERR=1; one transaction of 1 beat with SOP=EOP=1; the next correct frame is processed normally with ERR remaining 1.
- RESET asserted for 1 cycle mid-fragment (LEN_DW=300, beat 5) -> TX_DMA_SRC_RDY=0 the next cycle, FIFO empty; a new LEN_DW=16 frame then produces one correct transaction.
